// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the TPU front-end loader.
package tpu_pkg;

    // Loader control states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_D,
        ST_START,
        ST_WAIT
    } loader_state_t;

    // Sizing for the default configuration. Instances with other
    // parameters derive their own values the same way.
    localparam int DEF_SRAM_DATA_WIDTH = 32;
    localparam int DEF_DATA_WIDTH      = 8;
    localparam int DEF_QUEUE_COUNT     = 2;
    localparam int DEF_ADDR_MAX        = 127;

    localparam int BPW        = DEF_SRAM_DATA_WIDTH / DEF_DATA_WIDTH;
    localparam int WPR        = (DEF_ADDR_MAX + 1) * DEF_QUEUE_COUNT;
    localparam int ELEM_CNT_W = $clog2(BPW);
    localparam int WORD_CNT_W = $clog2(WPR);

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tpu_loader_byte_packer.sv
// Packs consecutive stream elements little-endian into one SRAM word.
// word_valid/word are combinational so the owner can register the write
// in the same cycle the last element of a word is accepted.
module byte_packer
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ELEMS      = 4
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic                          clear,
    input  logic                          in_fire,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          word_valid,
    output logic [ELEMS*DATA_WIDTH-1:0]   word
);

    localparam int ECW = cnt_width(ELEMS);

    logic [ECW-1:0]                cnt_q, cnt_d;
    logic [ELEMS*DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                          last_slot;

    // Insert the incoming element at its slot and compute the next fill state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        last_slot  = (cnt_q == ECW'(ELEMS - 1));
        word_valid = in_fire && last_slot;
        word       = buf_q;
        for (int j = 0; j < ELEMS; j++) begin
            if (cnt_q == ECW'(j)) begin
                word[j*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
        cnt_d = cnt_q;
        buf_d = buf_q;
        if (clear) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (in_fire) begin
            buf_d = word;
            cnt_d = last_slot ? '0 : cnt_q + 1'b1;
        end
    end

    // Element counter and partial-word register.
    always_ff @(posedge clk or negedge srstn) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (!srstn) begin
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/tpu_loader.sv
// Front-end loader for tpu_top: packs a byte stream into SRAM words, fills
// the weight banks then the data banks, starts the core and waits for done.
module tpu_loader
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE      = 8,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int DATA_WIDTH      = 8,
    parameter int QUEUE_COUNT     = (ARRAY_SIZE + 3) / 4,
    parameter int ADDR_MAX        = 127,
    parameter int SRAM_ADDR_WIDTH = 10
) (
    input  logic                                   clk,
    input  logic                                   srstn,
    input  logic                                   load_start,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   in_last,
    output logic [QUEUE_COUNT-1:0]                 sram_wen_w_packed,
    output logic [QUEUE_COUNT*SRAM_ADDR_WIDTH-1:0] sram_waddr_w_packed,
    output logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] sram_wdata_w_packed,
    output logic [QUEUE_COUNT-1:0]                 sram_wen_d_packed,
    output logic [QUEUE_COUNT*SRAM_ADDR_WIDTH-1:0] sram_waddr_d_packed,
    output logic [QUEUE_COUNT*SRAM_DATA_WIDTH-1:0] sram_wdata_d_packed,
    output logic                                   tpu_start,
    input  logic                                   tpu_done,
    output logic                                   busy,
    output logic                                   load_err
);

    localparam int ELEMS_PER_WORD   = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam int WORDS_PER_REGION = (ADDR_MAX + 1) * QUEUE_COUNT;
    localparam int WCW              = cnt_width(WORDS_PER_REGION);
    localparam int BCW              = cnt_width(QUEUE_COUNT);

    // Reject configurations where elements do not tile a word exactly.
    if ((SRAM_DATA_WIDTH % DATA_WIDTH) != 0 || ARRAY_SIZE < 1) begin : g_param_check
        $error("tpu_loader: SRAM_DATA_WIDTH must be a multiple of DATA_WIDTH");
    end

    loader_state_t          state_q;
    logic                   in_ready_q, busy_q, tpu_start_q, load_err_q;
    logic [WCW-1:0]         word_cnt_q;
    logic [BCW-1:0]         bank_q;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q;

    logic [QUEUE_COUNT-1:0]                           wen_w_q, wen_d_q;
    logic [QUEUE_COUNT-1:0][SRAM_ADDR_WIDTH-1:0]      waddr_w_q, waddr_d_q;
    logic [QUEUE_COUNT-1:0][SRAM_DATA_WIDTH-1:0]      wdata_w_q, wdata_d_q;

    logic                          fire;
    logic                          pk_word_valid;
    logic [SRAM_DATA_WIDTH-1:0]    pk_word;
    logic                          pk_clear;
    logic                          last_word;
    logic                          final_elem;
    logic                          frame_err;
    logic                          wr_en;

    // in_ready_q is high exactly in the two load states, so it doubles as
    // the "accepting" qualifier.
    assign fire       = in_valid && in_ready_q;
    assign last_word  = (word_cnt_q == WCW'(WORDS_PER_REGION - 1));
    assign final_elem = (state_q == ST_LOAD_D) && last_word && pk_word_valid;
    // in_last must coincide exactly with the final element of the load.
    assign frame_err  = fire && (in_last != final_elem);
    // The element that triggers a framing error is never committed.
    assign wr_en      = pk_word_valid && !frame_err;
    assign pk_clear   = frame_err || ((state_q == ST_IDLE) && load_start);

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ELEMS      (ELEMS_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .srstn      (srstn),
        .clear      (pk_clear),
        .in_fire    (fire),
        .in_data    (in_data),
        .word_valid (pk_word_valid),
        .word       (pk_word)
    );

    // Control FSM with registered status outputs, word counter and bank/address walk.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            tpu_start_q <= 1'b0;
            load_err_q  <= 1'b0;
            word_cnt_q  <= '0;
            bank_q      <= '0;
            addr_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        state_q    <= ST_LOAD_W;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        load_err_q <= 1'b0;
                        word_cnt_q <= '0;
                        bank_q     <= '0;
                        addr_q     <= '0;
                    end
                end
                ST_LOAD_W, ST_LOAD_D: begin
                    if (frame_err) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        load_err_q <= 1'b1;
                        word_cnt_q <= '0;
                        bank_q     <= '0;
                        addr_q     <= '0;
                    end else if (wr_en) begin
                        if (last_word) begin
                            word_cnt_q <= '0;
                            bank_q     <= '0;
                            addr_q     <= '0;
                            if (state_q == ST_LOAD_W) begin
                                // in_ready stays high: no bubble between regions.
                                state_q <= ST_LOAD_D;
                            end else begin
                                state_q     <= ST_START;
                                in_ready_q  <= 1'b0;
                                tpu_start_q <= 1'b1;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            if (bank_q == BCW'(QUEUE_COUNT - 1)) begin
                                bank_q <= '0;
                                addr_q <= addr_q + 1'b1;
                            end else begin
                                bank_q <= bank_q + 1'b1;
                            end
                        end
                    end
                end
                ST_START: begin
                    tpu_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tpu_done) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    tpu_start_q <= 1'b0;
                end
            endcase
        end
    end

    // SRAM write-port registers: one-cycle wen pulse, address/data held between writes.
    always_ff @(posedge clk or negedge srstn) begin
        // NOTE: these are port registers, not storage arrays, so they take the reset; the SRAM contents themselves are never reset here.
        if (!srstn) begin
            wen_w_q   <= '0;
            wen_d_q   <= '0;
            waddr_w_q <= '0;
            waddr_d_q <= '0;
            wdata_w_q <= '0;
            wdata_d_q <= '0;
        end else begin
            wen_w_q <= '0;
            wen_d_q <= '0;
            if (wr_en) begin
                if (state_q == ST_LOAD_W) begin
                    wen_w_q[bank_q]   <= 1'b1;
                    waddr_w_q[bank_q] <= addr_q;
                    wdata_w_q[bank_q] <= pk_word;
                end else begin
                    wen_d_q[bank_q]   <= 1'b1;
                    waddr_d_q[bank_q] <= addr_q;
                    wdata_d_q[bank_q] <= pk_word;
                end
            end
        end
    end

    assign in_ready            = in_ready_q;
    assign busy                = busy_q;
    assign tpu_start           = tpu_start_q;
    assign load_err            = load_err_q;
    assign sram_wen_w_packed   = wen_w_q;
    assign sram_waddr_w_packed = waddr_w_q;
    assign sram_wdata_w_packed = wdata_w_q;
    assign sram_wen_d_packed   = wen_d_q;
    assign sram_waddr_d_packed = waddr_d_q;
    assign sram_wdata_d_packed = wdata_d_q;

endmodule

// File: tb/tb_tpu_loader.sv
// Self-checking bench for tpu_loader with ADDR_MAX=3, QUEUE_COUNT=2, BPW=4.
module tb_tpu_loader;

    localparam int QC  = 2;
    localparam int AW  = 10;
    localparam int SDW = 32;
    localparam int DW  = 8;
    localparam int AMX = 3;

    logic            clk = 1'b0;
    logic            srstn;
    logic            load_start;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic [QC-1:0]     sram_wen_w_packed,   sram_wen_d_packed;
    logic [QC*AW-1:0]  sram_waddr_w_packed, sram_waddr_d_packed;
    logic [QC*SDW-1:0] sram_wdata_w_packed, sram_wdata_d_packed;
    logic            tpu_start;
    logic            tpu_done;
    logic            busy;
    logic            load_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Shadow of the SRAM contents, built from observed write ports.
    logic [SDW-1:0] mem [2][QC][AMX+1];
    int n_writes = 0;
    int n_starts = 0;
    int n_multi  = 0;
    int n_badaddr = 0;

    always #5 clk = ~clk;

    tpu_loader #(
        .ARRAY_SIZE      (8),
        .SRAM_DATA_WIDTH (SDW),
        .DATA_WIDTH      (DW),
        .QUEUE_COUNT     (QC),
        .ADDR_MAX        (AMX),
        .SRAM_ADDR_WIDTH (AW)
    ) dut (
        .clk                 (clk),
        .srstn               (srstn),
        .load_start          (load_start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .in_last             (in_last),
        .sram_wen_w_packed   (sram_wen_w_packed),
        .sram_waddr_w_packed (sram_waddr_w_packed),
        .sram_wdata_w_packed (sram_wdata_w_packed),
        .sram_wen_d_packed   (sram_wen_d_packed),
        .sram_waddr_d_packed (sram_waddr_d_packed),
        .sram_wdata_d_packed (sram_wdata_d_packed),
        .tpu_start           (tpu_start),
        .tpu_done            (tpu_done),
        .busy                (busy),
        .load_err            (load_err)
    );

    // Write-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int nb;
        logic [AW-1:0] a;
        nb = $countones(sram_wen_w_packed) + $countones(sram_wen_d_packed);
        n_writes += nb;
        if (nb > 1) n_multi++;
        if (tpu_start) n_starts++;
        for (int b = 0; b < QC; b++) begin
            if (sram_wen_w_packed[b]) begin
                a = sram_waddr_w_packed[b*AW +: AW];
                if (a > AW'(AMX)) n_badaddr++;
                else mem[0][b][a[1:0]] = sram_wdata_w_packed[b*SDW +: SDW];
            end
            if (sram_wen_d_packed[b]) begin
                a = sram_waddr_d_packed[b*AW +: AW];
                if (a > AW'(AMX)) n_badaddr++;
                else mem[1][b][a[1:0]] = sram_wdata_d_packed[b*SDW +: SDW];
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_model();
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < QC; b++)
                for (int a = 0; a <= AMX; a++)
                    mem[r][b][a] = '0;
        n_writes = 0;
        n_starts = 0;
    endtask

    // Expected word for region r, bank b, address a when the stream is 0,1,2,...
    function automatic logic [SDW-1:0] exp_word(input int r, input int b, input int a);
        int base;
        base = r * 32 + (a * QC + b) * 4;
        return {8'(base + 3), 8'(base + 2), 8'(base + 1), 8'(base)};
    endfunction

    task automatic begin_load();
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
    endtask

    // Present one element and hold it until accepted (bounded).
    task automatic push(input logic [DW-1:0] d, input logic last, input logic ls);
        int budget;
        budget = 20;
        in_valid = 1'b1; in_data = d; in_last = last; load_start = ls;
        while (in_ready !== 1'b1 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check("push_ready_timeout", {63'd0, in_ready}, 64'd1);
        tick(1);
        in_valid = 1'b0; in_last = 1'b0; load_start = 1'b0;
    endtask

    task automatic stream(input int gap, input int last_at, input int n, input int ls_at);
        for (int i = 0; i < n; i++) begin
            if (gap > 0) tick($urandom_range(0, gap));
            push(8'(i), (i == last_at), (i == ls_at));
        end
    endtask

    task automatic check_mem(input string tag);
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < QC; b++)
                for (int a = 0; a <= AMX; a++)
                    check($sformatf("%s_mem_r%0d_b%0d_a%0d", tag, r, b, a), mem[r][b][a], exp_word(r, b, a));
    endtask

    // Called right after the final element is accepted: START, WAIT, done.
    task automatic finish_wait(input string tag, input bit poke);
        check({tag, "_start_pulse"}, tpu_start, 1);
        check({tag, "_last_wen_d"}, sram_wen_d_packed, 2'b10);
        check({tag, "_busy_start"}, busy, 1);
        tick(1);
        check({tag, "_start_low"}, tpu_start, 0);
        check({tag, "_busy_wait"}, busy, 1);
        if (poke) begin
            load_start = 1'b1;
            tick(1);
            load_start = 1'b0;
            check({tag, "_wait_ignores_start_busy"}, busy, 1);
            check({tag, "_wait_ignores_start_ready"}, in_ready, 0);
            tick(3);
        end else begin
            tick(4);
        end
        tpu_done = 1'b1;
        tick(1);
        tpu_done = 1'b0;
        check({tag, "_busy_after_done"}, busy, 0);
        check({tag, "_ready_after_done"}, in_ready, 0);
    endtask

    typedef struct {
        string name;
        int    gap;
        int    last_at;
        int    n;
        int    ls_at;
        bit    exp_err;
        int    exp_writes;
    } scen_t;

    scen_t scen [5];

    initial begin
        scen[0] = '{"b2b",          0, 63, 64, -1, 1'b0, 16};
        scen[1] = '{"early_last",   0, 20, 21, -1, 1'b1,  5};
        scen[2] = '{"gaps",         3, 63, 64, -1, 1'b0, 16};
        scen[3] = '{"no_last",      1, -1, 64, -1, 1'b1, -1};
        scen[4] = '{"ls_in_load_d", 0, 63, 64, 40, 1'b0, 16};

        srstn = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; tpu_done = 1'b0;
        tick(2);
        check("reset_outputs",
              {in_ready, tpu_start, busy, load_err, |sram_wen_w_packed, |sram_wen_d_packed,
               |sram_waddr_w_packed, |sram_waddr_d_packed, |sram_wdata_w_packed, |sram_wdata_d_packed}, '0);
        srstn = 1'b1;
        tick(1);
        check("idle_after_reset", {in_ready, busy, tpu_start, load_err}, '0);

        // tpu_done outside WAIT must not disturb IDLE.
        tpu_done = 1'b1;
        tick(1);
        tpu_done = 1'b0;
        check("done_ignored_idle", {busy, in_ready}, '0);

        for (int s = 0; s < 5; s++) begin
            clear_model();
            begin_load();
            check({scen[s].name, "_ready"}, in_ready, 1);
            check({scen[s].name, "_busy"}, busy, 1);
            check({scen[s].name, "_err_cleared"}, load_err, 0);
            stream(scen[s].gap, scen[s].last_at, scen[s].n, scen[s].ls_at);
            if (!scen[s].exp_err) begin
                finish_wait(scen[s].name, scen[s].ls_at >= 0);
                check_mem(scen[s].name);
                check({scen[s].name, "_err"}, load_err, 0);
            end else begin
                check({scen[s].name, "_err_set"}, load_err, 1);
                check({scen[s].name, "_err_busy"}, busy, 0);
                check({scen[s].name, "_err_ready"}, in_ready, 0);
                tick(3);
                check({scen[s].name, "_err_sticky"}, load_err, 1);
            end
            check({scen[s].name, "_starts"}, n_starts, scen[s].exp_err ? 0 : 1);
            if (scen[s].exp_writes >= 0)
                check({scen[s].name, "_writes"}, n_writes, scen[s].exp_writes);
            if (s == 0) begin
                check("spot_w_b0_a0", mem[0][0][0], 32'h03020100);
                check("spot_w_b1_a0", mem[0][1][0], 32'h07060504);
                check("spot_d_b1_a3", mem[1][1][3], 32'h3F3E3D3C);
            end
        end

        // Reset pulse after element 30 aborts the load immediately.
        clear_model();
        begin_load();
        stream(0, -1, 31, -1);
        check("abort_writes_before", n_writes, 7);
        srstn = 1'b0;
        #1;
        check("abort_outputs_zero",
              {in_ready, tpu_start, busy, load_err, |sram_wen_w_packed, |sram_wen_d_packed,
               |sram_waddr_w_packed, |sram_waddr_d_packed, |sram_wdata_w_packed, |sram_wdata_d_packed}, '0);
        tick(2);
        srstn = 1'b1;
        tick(2);
        check("abort_no_late_write", n_writes, 7);
        check("abort_idle", {busy, in_ready}, '0);

        clear_model();
        begin_load();
        stream(0, 63, 64, -1);
        finish_wait("post_abort", 1'b0);
        check_mem("post_abort");
        check("post_abort_starts", n_starts, 1);

        check("single_bank_wen", n_multi, 0);
        check("addr_in_range", n_badaddr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
